// File: rtl/rv32i_exec_ctrl_pkg.sv
// Shared types and constants for the RV32I execute/control slice:
// opcodes, ALU operation codes and write-back source codes.
package rv32i_exec_ctrl_pkg;

  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] ILTYPE = 7'b0000011;
  localparam logic [6:0] STYPE  = 7'b0100011;
  localparam logic [6:0] BTYPE  = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_BR   = 2'b01,
    WB_LOAD = 2'b10,
    WB_JUMP = 2'b11
  } wb_sel_e;

  // R-type and I-ALU share the funct3 map; only the SUB/SRA qualifiers differ.
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3,
                                             input logic       alt_sub,
                                             input logic       alt_sra);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decode.sv
// Instruction decoder: turns opcode/funct3/funct7 into datapath control.
// Branch resolution is left to the top, which owns the comparator.
module rv32i_decode
  import rv32i_exec_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        op1_sel_o,
  output logic        op2_sel_o,
  output logic [3:0]  alu_op_o,
  output logic        br_unsign_o,
  output logic        rd_wren_o,
  output logic        mem_wren_o,
  output logic [1:0]  wb_sel_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_e    alu_op;
  wb_sel_e    wb_sel;
  logic       unused_instr_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    op1_sel_o   = 1'b0;
    op2_sel_o   = 1'b0;
    alu_op      = ALU_ADD;
    br_unsign_o = 1'b0;
    rd_wren_o   = 1'b0;
    mem_wren_o  = 1'b0;
    wb_sel      = WB_ALU;
    branch_o    = 1'b0;
    jump_o      = 1'b0;
    illegal_o   = 1'b0;

    case (opcode)
      RTYPE: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          rd_wren_o = 1'b1;
          alu_op    = alu_op_from_f3(funct3, funct7[5], funct7[5]);
        end else begin
          illegal_o = 1'b1;
        end
      end
      ITYPE: begin
        op2_sel_o = 1'b1;
        rd_wren_o = 1'b1;
        alu_op    = alu_op_from_f3(funct3, 1'b0, funct7[5]);
      end
      ILTYPE: begin
        op2_sel_o = 1'b1;
        rd_wren_o = 1'b1;
        wb_sel    = WB_LOAD;
      end
      STYPE: begin
        op2_sel_o  = 1'b1;
        mem_wren_o = 1'b1;
      end
      BTYPE: begin
        // funct3 010/011 are unassigned branch encodings.
        if (funct3[2:1] == 2'b01) begin
          illegal_o = 1'b1;
        end else begin
          op1_sel_o   = 1'b1;
          op2_sel_o   = 1'b1;
          wb_sel      = WB_BR;
          br_unsign_o = funct3[1];
          branch_o    = 1'b1;
        end
      end
      JAL: begin
        op1_sel_o = 1'b1;
        op2_sel_o = 1'b1;
        rd_wren_o = 1'b1;
        wb_sel    = WB_JUMP;
        jump_o    = 1'b1;
      end
      JALR: begin
        op2_sel_o = 1'b1;
        rd_wren_o = 1'b1;
        wb_sel    = WB_JUMP;
        jump_o    = 1'b1;
      end
      LUI: begin
        op2_sel_o = 1'b1;
        rd_wren_o = 1'b1;
        alu_op    = ALU_PASSB;
      end
      AUIPC: begin
        op1_sel_o = 1'b1;
        op2_sel_o = 1'b1;
        rd_wren_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign alu_op_o = alu_op;
  assign wb_sel_o = wb_sel;

endmodule

// File: rtl/rv32i_exec_ctrl.sv
// Single-cycle RV32I decode + branch compare + ALU, with a small registered
// debug section (last ALU result, sticky illegal-instruction flag).
module rv32i_exec_ctrl
  import rv32i_exec_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        pc_sel_o,
  output logic        op1_sel_o,
  output logic        op2_sel_o,
  output logic [3:0]  alu_op_o,
  output logic        br_unsign_o,
  output logic        rd_wren_o,
  output logic        mem_wren_o,
  output logic [1:0]  wb_sel_o,
  output logic        br_less_o,
  output logic        br_equal_o,
  output logic        br_taken_o,
  output logic [31:0] alu_res_o,
  output logic        illegal_o,
  output logic [31:0] res_q_o,
  output logic        illegal_q_o
);

  logic        branch;
  logic        jump;
  logic        br_cond;
  logic [4:0]  shamt;
  logic [31:0] res_d, res_q;
  logic        illegal_d, illegal_q;

  rv32i_decode u_decode (
    .instr_i     (instr_i),
    .op1_sel_o   (op1_sel_o),
    .op2_sel_o   (op2_sel_o),
    .alu_op_o    (alu_op_o),
    .br_unsign_o (br_unsign_o),
    .rd_wren_o   (rd_wren_o),
    .mem_wren_o  (mem_wren_o),
    .wb_sel_o    (wb_sel_o),
    .branch_o    (branch),
    .jump_o      (jump),
    .illegal_o   (illegal_o)
  );

  assign br_equal_o = (rs1_i == rs2_i);
  assign br_less_o  = br_unsign_o ? (rs1_i < rs2_i) : ($signed(rs1_i) < $signed(rs2_i));

  always_comb begin
    br_cond = 1'b0;
    case (instr_i[14:12])
      3'b000:         br_cond = br_equal_o;
      3'b001:         br_cond = !br_equal_o;
      3'b100, 3'b110: br_cond = br_less_o;
      3'b101, 3'b111: br_cond = !br_less_o;
      default:        br_cond = 1'b0;
    endcase
  end

  assign br_taken_o = branch & br_cond;
  assign pc_sel_o   = jump | br_taken_o;

  assign shamt = op2_i[4:0];

  always_comb begin
    alu_res_o = '0;
    case (alu_op_e'(alu_op_o))
      ALU_ADD:   alu_res_o = op1_i + op2_i;
      ALU_SUB:   alu_res_o = op1_i - op2_i;
      ALU_SLL:   alu_res_o = op1_i << shamt;
      ALU_SLT:   alu_res_o = {31'd0, $signed(op1_i) < $signed(op2_i)};
      ALU_SLTU:  alu_res_o = {31'd0, op1_i < op2_i};
      ALU_XOR:   alu_res_o = op1_i ^ op2_i;
      ALU_SRL:   alu_res_o = op1_i >> shamt;
      ALU_SRA:   alu_res_o = $unsigned($signed(op1_i) >>> shamt);
      ALU_OR:    alu_res_o = op1_i | op2_i;
      ALU_AND:   alu_res_o = op1_i & op2_i;
      ALU_PASSB: alu_res_o = op2_i;
      default:   alu_res_o = '0;
    endcase
  end

  assign res_d     = alu_res_o;
  assign illegal_d = illegal_q | illegal_o;

  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (!rst_ni) begin
      res_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      res_q     <= res_d;
      illegal_q <= illegal_d;
    end
  end

  assign res_q_o     = res_q;
  assign illegal_q_o = illegal_q;

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// Self-checking bench for rv32i_exec_ctrl: directed test-plan cases plus
// randomized instructions checked against an instruction-level reference model.
module tb_rv32i_exec_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] instr_i, op1_i, op2_i, rs1_i, rs2_i;
  logic        pc_sel_o, op1_sel_o, op2_sel_o, br_unsign_o, rd_wren_o, mem_wren_o;
  logic [3:0]  alu_op_o;
  logic [1:0]  wb_sel_o;
  logic        br_less_o, br_equal_o, br_taken_o, illegal_o, illegal_q_o;
  logic [31:0] alu_res_o, res_q_o;

  always #5 clk_i = ~clk_i;

  rv32i_exec_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .instr_i     (instr_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .pc_sel_o    (pc_sel_o),
    .op1_sel_o   (op1_sel_o),
    .op2_sel_o   (op2_sel_o),
    .alu_op_o    (alu_op_o),
    .br_unsign_o (br_unsign_o),
    .rd_wren_o   (rd_wren_o),
    .mem_wren_o  (mem_wren_o),
    .wb_sel_o    (wb_sel_o),
    .br_less_o   (br_less_o),
    .br_equal_o  (br_equal_o),
    .br_taken_o  (br_taken_o),
    .alu_res_o   (alu_res_o),
    .illegal_o   (illegal_o),
    .res_q_o     (res_q_o),
    .illegal_q_o (illegal_q_o)
  );

  typedef struct packed {
    logic        pc_sel;
    logic        op1_sel;
    logic        op2_sel;
    logic [3:0]  alu_op;
    logic        br_unsign;
    logic        rd_wren;
    logic        mem_wren;
    logic [1:0]  wb_sel;
    logic        br_less;
    logic        br_equal;
    logic        br_taken;
    logic [31:0] alu_res;
    logic        illegal;
  } ctl_t;

  ctl_t obs;
  assign obs = {pc_sel_o, op1_sel_o, op2_sel_o, alu_op_o, br_unsign_o, rd_wren_o,
                mem_wren_o, wb_sel_o, br_less_o, br_equal_o, br_taken_o, alu_res_o,
                illegal_o};

  int n_cmp = 0;
  int n_fail = 0;

  // funct3 -> base ALU op code for R-type / I-ALU
  localparam logic [3:0] F3_OPS [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  function automatic logic signed_lt(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    ext = {{32{a[31]}}, a} >> b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a * (32'd1 << b[4:0]);
      4'd3:  return signed_lt(a, b) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a / (32'd1 << b[4:0]);
      4'd7:  return ext[31:0];
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic ctl_t model(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] r1,
                                 input logic [31:0] r2);
    ctl_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_br;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    e = '0;
    is_br = 1'b0;
    case (opc)
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          e.rd_wren = 1'b1;
          e.alu_op  = F3_OPS[f3];
          if (f3 == 3'd0 && f7[5]) e.alu_op = 4'd1;
          if (f3 == 3'd5 && f7[5]) e.alu_op = 4'd7;
        end else e.illegal = 1'b1;
      end
      7'h13: begin
        e.op2_sel = 1'b1; e.rd_wren = 1'b1;
        e.alu_op  = F3_OPS[f3];
        if (f3 == 3'd5 && f7[5]) e.alu_op = 4'd7;
      end
      7'h03: begin e.op2_sel = 1'b1; e.rd_wren = 1'b1; e.wb_sel = 2'b10; end
      7'h23: begin e.op2_sel = 1'b1; e.mem_wren = 1'b1; end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) e.illegal = 1'b1;
        else begin
          e.op1_sel = 1'b1; e.op2_sel = 1'b1; e.wb_sel = 2'b01;
          e.br_unsign = f3[1]; is_br = 1'b1;
        end
      end
      7'h6F: begin e.op1_sel = 1'b1; e.op2_sel = 1'b1; e.rd_wren = 1'b1; e.wb_sel = 2'b11; e.pc_sel = 1'b1; end
      7'h67: begin e.op2_sel = 1'b1; e.rd_wren = 1'b1; e.wb_sel = 2'b11; e.pc_sel = 1'b1; end
      7'h37: begin e.op2_sel = 1'b1; e.rd_wren = 1'b1; e.alu_op = 4'd10; end
      7'h17: begin e.op1_sel = 1'b1; e.op2_sel = 1'b1; e.rd_wren = 1'b1; end
      default: e.illegal = 1'b1;
    endcase
    e.br_equal = (r1 == r2);
    e.br_less  = e.br_unsign ? (r1 < r2) : signed_lt(r1, r2);
    if (is_br) begin
      case (f3)
        3'd0:       e.br_taken = e.br_equal;
        3'd1:       e.br_taken = !e.br_equal;
        3'd4, 3'd6: e.br_taken = e.br_less;
        default:    e.br_taken = !e.br_less;
      endcase
      e.pc_sel = e.br_taken;
    end
    e.alu_res = alu_ref(e.alu_op, a, b);
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r1, input logic [31:0] r2);
    instr_i = ins; op1_i = a; op2_i = b; rs1_i = r1; rs2_i = r2;
    #1;
  endtask

  task automatic test_reset();
    ctl_t e;
    rst_ni = 1'b0;
    @(negedge clk_i);
    drive(32'h002081B3, 32'd5, 32'd7, 32'd0, 32'd0);
    @(posedge clk_i); #1;
    n_cmp++;
    if (res_q_o !== 32'd0 || illegal_q_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs got res_q=%h ill_q=%b want 0/0", res_q_o, illegal_q_o);
    end
    e = model(instr_i, op1_i, op2_i, rs1_i, rs2_i);
    n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_comb got %h want %h", obs, e);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_alu();
    logic [31:0] ins_t [6];
    logic [31:0] a_t   [6];
    logic [31:0] b_t   [6];
    logic [31:0] res_t [6];
    ctl_t e;
    ins_t = '{32'h002081B3, 32'h40208133, 32'h4020D133, 32'h0020B133, 32'h0020A133, 32'h123450B7};
    a_t   = '{32'd5, 32'd0, 32'h8000_0000, 32'd1, 32'd1, 32'd0};
    b_t   = '{32'd7, 32'd1, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5000};
    res_t = '{32'd12, 32'hFFFF_FFFF, 32'hF800_0000, 32'd1, 32'd0, 32'h1234_5000};
    for (int i = 0; i < 6; i++) begin
      drive(ins_t[i], a_t[i], b_t[i], 32'd0, 32'd0);
      e = model(ins_t[i], a_t[i], b_t[i], 32'd0, 32'd0);
      n_cmp++;
      if (alu_res_o !== res_t[i]) begin
        n_fail++;
        $display("FAIL alu_res[%0d] got %h want %h", i, alu_res_o, res_t[i]);
      end
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL alu_ctl[%0d] got %h want %h", i, obs, e);
      end
      if (i == 0) begin
        n_cmp++;
        if ({alu_op_o, rd_wren_o, wb_sel_o, pc_sel_o} !== 8'b0000_1_00_0) begin
          n_fail++;
          $display("FAIL add_ctl got op=%h rd=%b wb=%b pc=%b", alu_op_o, rd_wren_o, wb_sel_o, pc_sel_o);
        end
      end
    end
  endtask

  task automatic test_branch();
    drive(32'h0020C063, 32'h100, 32'h8, 32'hFFFF_FFFF, 32'd1);
    n_cmp++;
    if ({br_less_o, br_taken_o, pc_sel_o, wb_sel_o} !== 5'b111_01) begin
      n_fail++;
      $display("FAIL blt got less=%b taken=%b pc=%b wb=%b want 1 1 1 01", br_less_o, br_taken_o, pc_sel_o, wb_sel_o);
    end
    n_cmp++;
    if (alu_res_o !== 32'h108) begin
      n_fail++;
      $display("FAIL blt_target got %h want 00000108", alu_res_o);
    end
    drive(32'h0020E063, 32'h100, 32'h8, 32'hFFFF_FFFF, 32'd1);
    n_cmp++;
    if ({br_unsign_o, br_taken_o, pc_sel_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL bltu got uns=%b taken=%b pc=%b want 1 0 0", br_unsign_o, br_taken_o, pc_sel_o);
    end
    drive(32'h00209063, 32'h0, 32'h0, 32'd3, 32'd3);
    n_cmp++;
    if ({br_equal_o, br_taken_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL bne got eq=%b taken=%b want 1 0", br_equal_o, br_taken_o);
    end
  endtask

  task automatic test_mem_jump();
    drive(32'h0020A223, 32'h40, 32'h4, 32'd0, 32'd0);
    n_cmp++;
    if ({mem_wren_o, rd_wren_o, op2_sel_o} !== 3'b101) begin
      n_fail++;
      $display("FAIL sw got mem=%b rd=%b op2=%b want 1 0 1", mem_wren_o, rd_wren_o, op2_sel_o);
    end
    drive(32'h0000A103, 32'h40, 32'h4, 32'd0, 32'd0);
    n_cmp++;
    if (wb_sel_o !== 2'b10) begin
      n_fail++;
      $display("FAIL lw_wb got %b want 10", wb_sel_o);
    end
    drive(32'h000000EF, 32'h40, 32'h4, 32'd0, 32'd0);
    n_cmp++;
    if ({wb_sel_o, pc_sel_o, op1_sel_o} !== 4'b11_1_1) begin
      n_fail++;
      $display("FAIL jal got wb=%b pc=%b op1=%b want 11 1 1", wb_sel_o, pc_sel_o, op1_sel_o);
    end
  endtask

  task automatic test_illegal_sticky();
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    drive(32'hFFFF_FFFF, 32'd1, 32'd2, 32'd0, 32'd0);
    n_cmp++;
    if ({illegal_o, pc_sel_o, op1_sel_o, op2_sel_o, rd_wren_o, mem_wren_o, wb_sel_o, alu_op_o} !== 12'b1_00000_00_0000) begin
      n_fail++;
      $display("FAIL illegal_comb got ill=%b pc=%b o1=%b o2=%b rd=%b mem=%b wb=%b op=%h",
               illegal_o, pc_sel_o, op1_sel_o, op2_sel_o, rd_wren_o, mem_wren_o, wb_sel_o, alu_op_o);
    end
    n_cmp++;
    if (illegal_q_o !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_q_pre got %b want 0", illegal_q_o);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if (illegal_q_o !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_q_set got %b want 1", illegal_q_o);
    end
    drive(32'h002081B3, 32'd5, 32'd7, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      n_cmp++;
      if (illegal_q_o !== 1'b1 || res_q_o !== 32'd12) begin
        n_fail++;
        $display("FAIL illegal_q_hold[%0d] got ill_q=%b res_q=%h want 1 0000000c", i, illegal_q_o, res_q_o);
      end
    end
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    n_cmp++;
    if (illegal_q_o !== 1'b0 || res_q_o !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_q_clear got ill_q=%b res_q=%h want 0 0", illegal_q_o, res_q_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0]  opcs [9];
    logic [31:0] ins, a, b, r1, r2;
    logic        sticky;
    ctl_t        e;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    for (int round = 0; round < 4; round++) begin
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      sticky = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_i);
        ins = $urandom;
        if ($urandom_range(0, 15) != 0) begin
          ins[6:0] = opcs[$urandom_range(0, 8)];
          if (ins[6:0] == 7'h33 && $urandom_range(0, 7) != 0)
            ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        end
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        r1 = $urandom;
        r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
        if ($urandom_range(0, 3) == 0) r2 = r1 ^ 32'h8000_0000;
        drive(ins, a, b, r1, r2);
        e = model(ins, a, b, r1, r2);
        sticky = sticky | e.illegal;
        n_cmp++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL rand_comb ins=%h got %h want %h", ins, obs, e);
        end
        @(posedge clk_i); #1;
        n_cmp++;
        if (res_q_o !== e.alu_res || illegal_q_o !== sticky) begin
          n_fail++;
          $display("FAIL rand_regs ins=%h got res_q=%h ill_q=%b want %h %b",
                   ins, res_q_o, illegal_q_o, e.alu_res, sticky);
        end
      end
    end
  endtask

  initial begin
    rst_ni  = 1'b0;
    instr_i = '0; op1_i = '0; op2_i = '0; rs1_i = '0; rs2_i = '0;
    test_reset();
    test_alu();
    test_branch();
    test_mem_jump();
    test_illegal_sticky();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
